data_mem_responder: RTL and testbench

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

---
 rtl/data_mem_responder_pkg.sv | 20 ++
 rtl/data_mem_responder_array.sv | 24 ++
 rtl/data_mem_responder.sv | 122 ++++++++++++
 tb/tb_data_mem_responder.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/data_mem_responder_pkg.sv
// rtl/data_mem_responder_pkg.sv - shared state encodings and default sizing for the data memory responder
package data_mem_responder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int DEF_DATA_W      = 16;
    localparam int DEF_ADDR_W      = 16;
    localparam int DEF_DEPTH       = 256;
    localparam int DEF_WAIT_CYCLES = 2;
    localparam int CNT_W           = 4;

    function automatic int idx_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/data_mem_responder_array.sv
// rtl/data_mem_responder_array.sv - single-port word array, synchronous write, asynchronous read, no reset
module dmem_array #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 256,
    parameter int IDX_W  = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [IDX_W-1:0]  idx,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[idx] <= wdata;
        end
    end

    assign rdata = mem[idx];

endmodule

// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - wait-state memory responder: stalls the pipeline, then completes one access
module data_mem_responder
    import data_mem_responder_pkg::*;
#(
    parameter int DATA_W      = DEF_DATA_W,
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int DEPTH       = DEF_DEPTH,
    parameter int WAIT_CYCLES = DEF_WAIT_CYCLES
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic [ADDR_W-1:0] ADDR,
    input  logic [DATA_W-1:0] WDATA,
    output logic [DATA_W-1:0] RDATA,
    output logic              RVALID,
    output logic              Stall,
    output logic              ERR
);

    localparam int IDX_W = idx_width(DEPTH);
    localparam logic [CNT_W-1:0] CNT_LOAD = (WAIT_CYCLES > 0) ? CNT_W'(WAIT_CYCLES - 1) : '0;
    localparam bit ALL_IN_RANGE = (DEPTH >= (1 << ADDR_W));

    state_t            state, state_nx;
    logic [CNT_W-1:0]  cnt, cnt_nx;
    logic              cap_rd, cap_wr;
    logic [ADDR_W-1:0] cap_addr;
    logic [DATA_W-1:0] cap_wdata;

    logic              op_rd, op_wr, in_range, enter_done, arr_we;
    logic [ADDR_W-1:0] op_addr;
    logic [DATA_W-1:0] op_wdata, arr_rdata;

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        Stall    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (MemRead || MemWrite) begin
                    Stall    = 1'b1;
                    cnt_nx   = CNT_LOAD;
                    state_nx = (WAIT_CYCLES > 0) ? ST_BUSY : ST_DONE;
                end
            end
            ST_BUSY: begin
                Stall = 1'b1;
                if (cnt == '0) begin
                    state_nx = ST_DONE;
                end else begin
                    cnt_nx = cnt - 1'b1;
                end
            end
            ST_DONE:  state_nx = ST_IDLE;
            default:  state_nx = ST_IDLE;
        endcase
    end

    // With zero wait states the access completes on the edge leaving IDLE, before capture is visible.
    assign op_rd    = (state == ST_IDLE) ? MemRead  : cap_rd;
    assign op_wr    = (state == ST_IDLE) ? MemWrite : cap_wr;
    assign op_addr  = (state == ST_IDLE) ? ADDR     : cap_addr;
    assign op_wdata = (state == ST_IDLE) ? WDATA    : cap_wdata;

    assign in_range   = ALL_IN_RANGE || (op_addr < ADDR_W'(DEPTH));
    assign enter_done = (state_nx == ST_DONE);
    assign arr_we     = enter_done && op_wr && !op_rd && in_range && rst_n;

    dmem_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W)
    ) u_array (
        .clk    (clk),
        .we     (arr_we),
        .idx    (op_addr[IDX_W-1:0]),
        .wdata  (op_wdata),
        .rdata  (arr_rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            cap_rd    <= 1'b0;
            cap_wr    <= 1'b0;
            cap_addr  <= '0;
            cap_wdata <= '0;
            RDATA     <= '0;
            RVALID    <= 1'b0;
            ERR       <= 1'b0;
        end else begin
            state  <= state_nx;
            cnt    <= cnt_nx;
            RVALID <= 1'b0;
            ERR    <= 1'b0;
            if (state == ST_IDLE && (MemRead || MemWrite)) begin
                cap_rd    <= MemRead;
                cap_wr    <= MemWrite;
                cap_addr  <= ADDR;
                cap_wdata <= WDATA;
            end
            if (enter_done) begin
                if (op_rd && op_wr) begin
                    ERR <= 1'b1;
                end else if (!in_range) begin
                    ERR <= 1'b1;
                    if (op_rd) begin
                        RDATA  <= '0;
                        RVALID <= 1'b1;
                    end
                end else if (op_rd) begin
                    RDATA  <= arr_rdata;
                    RVALID <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// tb/tb_data_mem_responder.sv - scoreboard bench for data_mem_responder at WAIT_CYCLES=2 and WAIT_CYCLES=0
module tb_data_mem_responder;

    typedef struct {
        logic [15:0] rdata;
        logic        rvalid;
        logic        err;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        mem_read  [2];
    logic        mem_write [2];
    logic [15:0] addr_in   [2];
    logic [15:0] wdata_in  [2];
    logic [15:0] rdata     [2];
    logic        rvalid    [2];
    logic        stall     [2];
    logic        err       [2];

    int          waits     [2] = '{2, 0};
    logic [15:0] mdl_mem   [2][256];
    logic [15:0] mdl_rdata [2];
    exp_t        sb [$];
    int          total = 0;
    int          bad   = 0;

    data_mem_responder #(.WAIT_CYCLES(2)) u_dut_w2 (
        .clk(clk), .rst_n(rst_n), .MemRead(mem_read[0]), .MemWrite(mem_write[0]),
        .ADDR(addr_in[0]), .WDATA(wdata_in[0]), .RDATA(rdata[0]), .RVALID(rvalid[0]),
        .Stall(stall[0]), .ERR(err[0])
    );

    data_mem_responder #(.WAIT_CYCLES(0)) u_dut_w0 (
        .clk(clk), .rst_n(rst_n), .MemRead(mem_read[1]), .MemWrite(mem_write[1]),
        .ADDR(addr_in[1]), .WDATA(wdata_in[1]), .RDATA(rdata[1]), .RVALID(rvalid[1]),
        .Stall(stall[1]), .ERR(err[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_req(input int d);
        mem_read[d]  = 1'b0;
        mem_write[d] = 1'b0;
        addr_in[d]   = 16'h0;
        wdata_in[d]  = 16'h0;
    endtask

    // Drive one access, count stall cycles, check the DONE cycle against the scoreboard, then the hold cycle.
    task automatic access(input int d, input logic rd, input logic wr, input logic [15:0] a,
                          input logic [15:0] wd, input bit scramble, input string tag);
        exp_t e;
        exp_t got;
        int   n;
        e.rvalid = 1'b0;
        e.err    = 1'b0;
        if (rd && wr) begin
            e.err = 1'b1;
        end else if (a >= 16'd256) begin
            e.err = 1'b1;
            if (rd) begin
                mdl_rdata[d] = 16'h0;
                e.rvalid     = 1'b1;
            end
        end else if (rd) begin
            mdl_rdata[d] = mdl_mem[d][a[7:0]];
            e.rvalid     = 1'b1;
        end else begin
            mdl_mem[d][a[7:0]] = wd;
        end
        e.rdata = mdl_rdata[d];
        sb.push_back(e);

        @(negedge clk);
        mem_read[d]  = rd;
        mem_write[d] = wr;
        addr_in[d]   = a;
        wdata_in[d]  = wd;
        #1;
        n = 0;
        while (stall[d] === 1'b1 && n < 40) begin
            n++;
            @(negedge clk);
            if (scramble && n == 1) begin
                mem_read[d]  = 1'b0;
                mem_write[d] = 1'b0;
                addr_in[d]   = ~a;
                wdata_in[d]  = ~wd;
            end
            #1;
        end
        chk({tag, "_stall_cycles"}, n, waits[d] + 1);
        got.rdata  = rdata[d];
        got.rvalid = rvalid[d];
        got.err    = err[d];
        e = sb.pop_front();
        chk({tag, "_rvalid"}, got.rvalid, e.rvalid);
        chk({tag, "_err"}, got.err, e.err);
        chk({tag, "_rdata"}, got.rdata, e.rdata);
        clear_req(d);
        @(negedge clk);
        #1;
        chk({tag, "_hold_rdata"}, rdata[d], e.rdata);
        chk({tag, "_hold_rvalid"}, rvalid[d], 1'b0);
        chk({tag, "_hold_err"}, err[d], 1'b0);
    endtask

    initial begin
        int first;
        int second;
        int cyc;
        clear_req(0);
        clear_req(1);
        mdl_rdata[0] = 16'h0;
        mdl_rdata[1] = 16'h0;
        rst_n = 1'b0;
        #1;
        chk("reset_rdata", rdata[0], 16'h0);
        chk("reset_rvalid", rvalid[0], 1'b0);
        chk("reset_err", err[0], 1'b0);
        chk("reset_stall", stall[0], 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Basic write then read with two wait states
        access(0, 1'b0, 1'b1, 16'h0010, 16'hBEEF, 1'b0, "w2_wr_beef");
        access(0, 1'b1, 1'b0, 16'h0010, 16'h0000, 1'b0, "w2_rd_beef");
        chk("w2_rd_beef_const", rdata[0], 16'hBEEF);

        // Zero wait states, then back-to-back reads with the request held
        access(1, 1'b0, 1'b1, 16'h0010, 16'hBEEF, 1'b0, "w0_wr_beef");
        access(1, 1'b1, 1'b0, 16'h0010, 16'h0000, 1'b0, "w0_rd_beef");
        @(negedge clk);
        mem_read[1] = 1'b1;
        addr_in[1]  = 16'h0010;
        first = -1;
        second = -1;
        for (cyc = 0; cyc < 20 && second < 0; cyc++) begin
            @(negedge clk);
            #1;
            if (rvalid[1] === 1'b1) begin
                if (first < 0) first = cyc;
                else second = cyc;
            end
        end
        chk("w0_b2b_found", second >= 0, 1'b1);
        chk("w0_b2b_spacing", second - first, 2);
        chk("w0_b2b_rdata", rdata[1], 16'hBEEF);
        clear_req(1);

        // Read and write asserted together
        access(0, 1'b1, 1'b1, 16'h0010, 16'h1234, 1'b0, "w2_both");
        access(0, 1'b1, 1'b0, 16'h0010, 16'h0000, 1'b0, "w2_rd_after_both");
        chk("w2_rd_after_both_const", rdata[0], 16'hBEEF);

        // Out-of-range accesses; 0x0100 aliases 0x0000 in the low bits
        access(0, 1'b0, 1'b1, 16'h0000, 16'h7777, 1'b0, "w2_wr_zero");
        access(0, 1'b1, 1'b0, 16'h0100, 16'h0000, 1'b0, "w2_rd_oor");
        access(0, 1'b0, 1'b1, 16'h0100, 16'hAAAA, 1'b0, "w2_wr_oor");
        access(0, 1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0, "w2_rd_zero");
        chk("w2_rd_zero_const", rdata[0], 16'h7777);

        // Inputs change and request drops during BUSY: the latched access still completes
        access(0, 1'b0, 1'b1, 16'h0030, 16'h4242, 1'b1, "w2_wr_scr");
        access(0, 1'b1, 1'b0, 16'h0030, 16'h0000, 1'b1, "w2_rd_scr");
        chk("w2_rd_scr_const", rdata[0], 16'h4242);

        // Reset in the second BUSY cycle of a write abandons it
        access(0, 1'b0, 1'b1, 16'h0020, 16'h1111, 1'b0, "w2_wr_1111");
        access(0, 1'b1, 1'b0, 16'h0020, 16'h0000, 1'b0, "w2_rd_1111");
        @(negedge clk);
        mem_write[0] = 1'b1;
        addr_in[0]   = 16'h0020;
        wdata_in[0]  = 16'h5555;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst_busy_rdata", rdata[0], 16'h0);
        chk("rst_busy_rvalid", rvalid[0], 1'b0);
        chk("rst_busy_err", err[0], 1'b0);
        chk("rst_busy_stall_req", stall[0], 1'b1);
        clear_req(0);
        #1;
        chk("rst_busy_stall_noreq", stall[0], 1'b0);
        mdl_rdata[0] = 16'h0;
        mdl_rdata[1] = 16'h0;
        @(negedge clk);
        rst_n = 1'b1;
        access(0, 1'b1, 1'b0, 16'h0020, 16'h0000, 1'b0, "w2_rd_after_rst");
        chk("w2_rd_after_rst_const", rdata[0], 16'h1111);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
